l0_maxpool: RTL and testbench

- Stage directly downstream of the layer-0 conv/ReLU block.
- Consumes that block's 2x2 pooling windows: four 18-bit values per channel for two channels, one window per valid cycle.
- Applies 2x2 max pooling and stores the 13x13x2 pooled map in an internal buffer.
- Serves the buffer through a 1-cycle-latency read port to the layer-1 stage. Asserts `full` and pulses `done` once all 169 windows have been written.

---
 rtl/l0_maxpool.sv | 138 +++++++++++++
 tb/tb_l0_maxpool.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_maxpool.sv
// Layer-0 2x2 max-pool stage: two-channel pooling into a 13x13 buffer, served by a registered read port.
// Optional sticky overflow flag `ovf` is built when L0_MAXPOOL_OVF_EN is defined.
module l0_maxpool #(
  parameter int DW    = 18,
  parameter int NPOOL = 169,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tx_done,
  input  logic            in_vld,
  input  logic [4*DW-1:0] din_0,
  input  logic [4*DW-1:0] din_1,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   dout_0,
  output logic [DW-1:0]   dout_1,
  output logic            dout_vld,
  output logic            full,
`ifdef L0_MAXPOOL_OVF_EN
  output logic            ovf,
`endif
  output logic            done
);
  // state   | meaning
  // ST_FILL | accepting windows, buffer being written
  // ST_FULL | all NPOOL entries written, reads served, windows dropped
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  localparam logic [AW-1:0] LAST   = AW'(NPOOL - 1);
  localparam logic [AW:0]   NP_EXT = (AW + 1)'(NPOOL);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          full_q, full_d;
  logic          done_q, done_d;
  logic          s1_vld_q;
  logic          dout_vld_q;
  logic          zero_q;
  logic [DW-1:0] m01_0_q, m23_0_q, m01_1_q, m23_1_q;
  logic [DW-1:0] rdata_0_q, rdata_1_q;
  logic [DW-1:0] mem_0 [0:NPOOL-1];
  logic [DW-1:0] mem_1 [0:NPOOL-1];

  logic          last_wr, accept, rd_acc, rd_inrange;
  logic [DW-1:0] wr_0, wr_1;

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // The window that makes the last write is the last one accepted, so a
  // window arriving alongside that write is dropped rather than staged.
  always_comb begin
    last_wr    = s1_vld_q && (wr_cnt_q == LAST);
    accept     = in_vld && (state_q == ST_FILL) && !last_wr;
    rd_acc     = rd_en && full_q;
    rd_inrange = ({1'b0, rd_addr} < NP_EXT);
    wr_0       = umax(m01_0_q, m23_0_q);
    wr_1       = umax(m01_1_q, m23_1_q);
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    full_d     = full_q;
    done_d     = 1'b0;
    if (s1_vld_q) begin
      if (last_wr) begin
        state_d = ST_FULL;
        full_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      dout_vld_q <= 1'b0;
      zero_q     <= 1'b1;
    end else if (tx_done) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      dout_vld_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      full_q     <= full_d;
      done_q     <= done_d;
      s1_vld_q   <= accept;
      dout_vld_q <= rd_acc;
      if (rd_acc) zero_q <= !rd_inrange;
    end
  end

  // Datapath and buffer carry no reset so the arrays map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      m01_0_q <= umax(din_0[0*DW +: DW], din_0[1*DW +: DW]);
      m23_0_q <= umax(din_0[2*DW +: DW], din_0[3*DW +: DW]);
      m01_1_q <= umax(din_1[0*DW +: DW], din_1[1*DW +: DW]);
      m23_1_q <= umax(din_1[2*DW +: DW], din_1[3*DW +: DW]);
    end
    if (s1_vld_q && !tx_done) begin
      mem_0[wr_cnt_q] <= wr_0;
      mem_1[wr_cnt_q] <= wr_1;
    end
    if (rd_acc && rd_inrange) begin
      rdata_0_q <= mem_0[rd_addr];
      rdata_1_q <= mem_1[rd_addr];
    end
  end

`ifdef L0_MAXPOOL_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ovf_q <= 1'b0;
    else if (tx_done)                            ovf_q <= 1'b0;
    else if (in_vld && (state_q == ST_FULL))     ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`endif

  assign dout_0   = zero_q ? '0 : rdata_0_q;
  assign dout_1   = zero_q ? '0 : rdata_1_q;
  assign dout_vld = dout_vld_q;
  assign full     = full_q;
  assign done     = done_q;
endmodule

// File: tb/tb_l0_maxpool.sv
// Directed bench for l0_maxpool: fills, reads, clears, overflow drop and async reset.
module tb_l0_maxpool;
  localparam int DW = 18;
  localparam int NP = 169;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst_n, tx_done, in_vld, rd_en;
  logic [4*DW-1:0] din_0, din_1;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   dout_0, dout_1;
  logic            dout_vld, full, done;
`ifdef L0_MAXPOOL_OVF_EN
  logic            ovf;
`endif

  int nchk = 0;
  int nerr = 0;
  int done_seen;
  logic [4*DW-1:0] win0 [0:NP-1];
  logic [4*DW-1:0] win1 [0:NP-1];
  logic [DW-1:0]   exp0 [0:NP-1];
  logic [DW-1:0]   exp1 [0:NP-1];

  l0_maxpool #(.DW(DW), .NPOOL(NP), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_done(tx_done), .in_vld(in_vld),
    .din_0(din_0), .din_1(din_1), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout_0(dout_0), .dout_1(dout_1), .dout_vld(dout_vld), .full(full),
`ifdef L0_MAXPOOL_OVF_EN
    .ovf(ovf),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  function automatic logic [DW-1:0] max4(input logic [4*DW-1:0] w);
    logic [DW-1:0] m;
    m = w[DW-1:0];
    for (int i = 1; i < 4; i++) if (w[i*DW +: DW] > m) m = w[i*DW +: DW];
    return m;
  endfunction

  task automatic send(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    in_vld = 1'b1; din_0 = a; din_1 = b;
    step();
    in_vld = 1'b0;
  endtask

  task automatic run_frame(input int gap_max);
    done_seen = 0;
    for (int k = 0; k < NP; k++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
      send(win0[k], win1[k]);
    end
    chki("done_before_last_write", done_seen, 0);
    chk1("full_before_last_write", full, 1'b0);
    step();
    chk1("done_pulse", done, 1'b1);
    chk1("full_set", full, 1'b1);
    step();
    chk1("done_one_cycle", done, 1'b0);
    chk1("full_level", full, 1'b1);
    chki("done_count", done_seen, 1);
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < NP; k++) begin
      rd_en = 1'b1; rd_addr = AW'(k);
      step();
      chkd({tag, "_d0"}, dout_0, exp0[k]);
      chkd({tag, "_d1"}, dout_1, exp1[k]);
      chk1({tag, "_vld"}, dout_vld, 1'b1);
    end
    rd_en = 1'b0;
    step();
    chk1({tag, "_vld_idle"}, dout_vld, 1'b0);
  endtask

  task automatic read_one(input string tag, input int a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    rd_en = 1'b1; rd_addr = AW'(a);
    step();
    rd_en = 1'b0;
    chkd({tag, "_d0"}, dout_0, e0);
    chkd({tag, "_d1"}, dout_1, e1);
    chk1({tag, "_vld"}, dout_vld, 1'b1);
  endtask

  task automatic clear();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tx_done = 1'b0; in_vld = 1'b0; rd_en = 1'b0;
    din_0 = '0; din_1 = '0; rd_addr = '0; done_seen = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk1("rst_full", full, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_vld", dout_vld, 1'b0);
    chkd("rst_dout0", dout_0, 18'd0);
`ifdef L0_MAXPOOL_OVF_EN
    chk1("rst_ovf", ovf, 1'b0);
`endif

    // read while filling: no valid, dout held at 0
    rd_en = 1'b1; rd_addr = '0;
    step();
    rd_en = 1'b0;
    chk1("fill_rd_vld", dout_vld, 1'b0);
    chkd("fill_rd_dout0", dout_0, 18'd0);

    // frame A: single known window then ramp windows
    win0[0] = {18'd5, 18'd9, 18'd2, 18'd7}; exp0[0] = 18'd9;
    win1[0] = {18'd0, 18'd0, 18'd3, 18'd1}; exp1[0] = 18'd3;
    for (int k = 1; k < NP; k++) begin
      win0[k] = {DW'(k), DW'(k + 1), DW'(k + 3), DW'(k + 2)};
      win1[k] = win0[k];
      exp0[k] = DW'(k + 3);
      exp1[k] = DW'(k + 3);
    end
    run_frame(0);
    read_all("frmA");
    read_one("addr200", 200, 18'd0, 18'd0);

    // extra windows while full are dropped
    repeat (5) send({4{18'h3FFFF}}, {4{18'h3FFFF}});
    step(); step();
    chk1("extra_full", full, 1'b1);
    read_one("extra_a0", 0, 18'd9, 18'd3);
    read_one("extra_a168", 168, 18'd171, 18'd171);
`ifdef L0_MAXPOOL_OVF_EN
    chk1("ovf_set", ovf, 1'b1);
`endif

    clear();
    chk1("clr_full", full, 1'b0);
    chk1("clr_vld", dout_vld, 1'b0);
    chkd("clr_dout0", dout_0, 18'd0);
`ifdef L0_MAXPOOL_OVF_EN
    chk1("clr_ovf", ovf, 1'b0);
`endif

    // frame B: random values with random gaps
    for (int k = 0; k < NP; k++) begin
      for (int i = 0; i < 4; i++) begin
        win0[k][i*DW +: DW] = DW'($urandom_range(0, 18'h3FFFF));
        win1[k][i*DW +: DW] = DW'($urandom_range(0, 18'h3FFFF));
      end
      exp0[k] = max4(win0[k]);
      exp1[k] = max4(win1[k]);
    end
    run_frame(3);
    read_all("frmB");
    read_one("frmB_addr200", 200, 18'd0, 18'd0);

    // tx_done mid-frame with a window in stage 1
    clear();
    done_seen = 0;
    for (int k = 0; k < 81; k++) send(win0[k], win1[k]);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("abort_full", full, 1'b0);
    end
    chki("abort_no_done", done_seen, 0);
    for (int k = 0; k < NP; k++) begin
      win0[k] = {DW'(3 * k), DW'(k), DW'(1000 - k), DW'(2 * k)};
      win1[k] = {DW'(k), DW'(500), DW'(k), DW'(k)};
      exp0[k] = max4(win0[k]);
      exp1[k] = max4(win1[k]);
    end
    run_frame(0);
    read_all("frmC");

    // async reset in the middle of a read burst
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1; rd_addr = AW'(k + 10);
      step();
    end
    chk1("burst_vld", dout_vld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_vld", dout_vld, 1'b0);
    chk1("arst_full", full, 1'b0);
    chkd("arst_dout0", dout_0, 18'd0);
    chkd("arst_dout1", dout_1, 18'd0);
    rd_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < NP - 1; k++) send(win0[k], win1[k]);
    repeat (3) step();
    chk1("arst_not_full_168", full, 1'b0);
    send(win0[NP-1], win1[NP-1]);
    step(); step();
    chk1("arst_full_169", full, 1'b1);
    read_one("arst_a168", 168, exp0[168], exp1[168]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
